// File: rtl/sensor_request_conditioner.sv
// Front end for the traffic-light controller: synchronizes, debounces and
// latches pedestrian / east-west / north-south requests until serviced.
module sensor_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] raw_in,
  input  logic [2:0] clear,
  output logic [2:0] sensors,
  output logic [2:0] press,
  output logic       any_request
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       in_lvl;
  logic [2:0]       sync_q1;
  logic [2:0]       syncd;
  logic [2:0]       stable;
  logic [2:0]       accept;
  logic [2:0]       rise;
  logic [CNT_W-1:0] cnt [3];

  // Board pushbuttons idle high; everything downstream treats 1 as "active".
  assign in_lvl = (ACTIVE_LOW != 0) ? ~raw_in : raw_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      syncd   <= '0;
    end else begin
      sync_q1 <= in_lvl;
      syncd   <= sync_q1;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      accept[i] = (syncd[i] != stable[i]) && (cnt[i] == CNT_TC);
    end
  end

  assign rise = accept & syncd;

  // Counter only advances while the synced level disagrees, and restarts on
  // acceptance, so it never passes CNT_TC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (syncd[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= syncd[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A fresh press beats a simultaneous clear so no request is ever dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press   <= '0;
      sensors <= '0;
    end else begin
      press   <= rise;
      sensors <= rise | (sensors & ~clear);
    end
  end

  assign any_request = |sensors;

endmodule

// File: tb/tb_sensor_request_conditioner.sv
// Scoreboard bench: a window-based reference model predicts every cycle's
// outputs for an active-high and an active-low instance driven with mirrored inputs.
module tb_sensor_request_conditioner;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] raw_in = 3'b000;
  logic [2:0] raw_in_n;
  logic [2:0] clear = 3'b000;
  logic [2:0] sens_h, press_h, sens_l, press_l;
  logic       any_h, any_l;

  assign raw_in_n = ~raw_in;

  always #5 clk = ~clk;

  sensor_request_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(20), .ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst(rst), .raw_in(raw_in), .clear(clear),
    .sensors(sens_h), .press(press_h), .any_request(any_h)
  );

  sensor_request_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(20), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst(rst), .raw_in(raw_in_n), .clear(clear),
    .sensors(sens_l), .press(press_l), .any_request(any_l)
  );

  typedef struct packed {
    logic [2:0] s;
    logic [2:0] p;
    logic       a;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         press_cnt[3];

  logic [2:0] m_stable;
  logic [2:0] m_sens;
  logic [2:0] hist[$];   // hist[k] = logical input sampled k+1 edges ago

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: a level is accepted once the synchronized input (two edges
  // late) has disagreed with the accepted level for the last DB edges.
  always @(posedge clk) begin
    exp_t       e;
    logic [2:0] rise;
    bit         diff;
    if (!rst) begin
      m_stable = '0;
      m_sens   = '0;
      hist.delete();
      for (int j = 0; j < DB + 2; j++) hist.push_back(3'b000);
      e = '0;
    end else begin
      rise = '0;
      for (int i = 0; i < 3; i++) begin
        diff = 1'b1;
        for (int j = 1; j <= DB; j++)
          if (hist[j][i] == m_stable[i]) diff = 1'b0;
        if (diff) begin
          m_stable[i] = ~m_stable[i];
          if (m_stable[i]) rise[i] = 1'b1;
        end
      end
      hist.push_front(raw_in);
      void'(hist.pop_back());
      m_sens = rise | (m_sens & ~clear);
      e.s = m_sens;
      e.p = rise;
      e.a = |m_sens;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sensors_h", sens_h, e.s);
      chk("press_h", press_h, e.p);
      chk("any_h", {2'b00, any_h}, {2'b00, e.a});
      chk("sensors_l", sens_l, e.s);
      chk("press_l", press_l, e.p);
      chk("any_l", {2'b00, any_l}, {2'b00, e.a});
      for (int i = 0; i < 3; i++) if (press_h[i]) press_cnt[i]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [2:0] r, input int n);
    raw_in = r;
    tick(n);
  endtask

  task automatic pulse_clear(input logic [2:0] c);
    clear = c;
    tick(1);
    clear = 3'b000;
  endtask

  initial begin
    int pc0, pc1;
    int hold[3];
    logic [2:0] lvl;

    for (int i = 0; i < 3; i++) press_cnt[i] = 0;
    tick(3);
    rst = 1'b1;
    tick(2);

    // clean pedestrian press, then release and service
    set_raw(3'b100, 10);
    set_raw(3'b000, 10);
    pulse_clear(3'b100);
    tick(2);

    // bouncing east-west sensor
    set_raw(3'b010, 3);
    set_raw(3'b000, 2);
    set_raw(3'b010, 3);
    set_raw(3'b000, 2);
    set_raw(3'b010, 12);
    pulse_clear(3'b010);
    set_raw(3'b000, 10);

    // clear alone, then press colliding with clear on the same edge
    set_raw(3'b001, 10);
    pulse_clear(3'b001);
    set_raw(3'b000, 10);
    set_raw(3'b001, 10);
    set_raw(3'b000, 10);
    raw_in = 3'b001;
    tick(5);
    pulse_clear(3'b001);
    tick(4);
    pulse_clear(3'b001);
    set_raw(3'b000, 10);

    // held buttons produce a single request each
    pc0 = press_cnt[0];
    pc1 = press_cnt[1];
    set_raw(3'b011, 20);
    pulse_clear(3'b011);
    tick(29);
    chk("held_press_ch0", 3'(press_cnt[0] - pc0), 3'd1);
    chk("held_press_ch1", 3'(press_cnt[1] - pc1), 3'd1);
    chk("held_no_reassert", sens_h, 3'b000);
    set_raw(3'b000, 10);

    // reset in the middle of a debounce count, button still held at release
    set_raw(3'b001, 10);
    raw_in = 3'b101;
    tick(4);
    rst = 1'b0;
    #1;
    chk("async_rst_sensors", sens_h, 3'b000);
    chk("async_rst_press", press_h, 3'b000);
    chk("async_rst_any", {2'b00, any_h}, 3'b000);
    chk("async_rst_sensors_l", sens_l, 3'b000);
    tick(2);
    rst = 1'b1;
    tick(10);
    set_raw(3'b000, 10);
    pulse_clear(3'b111);
    tick(2);

    // randomized bouncy inputs, random service and occasional resets
    for (int i = 0; i < 3; i++) hold[i] = 0;
    lvl = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          lvl[i]  = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 9);
        end
        hold[i]--;
      end
      raw_in = lvl;
      clear  = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      rst    = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    rst = 1'b1;
    clear = 3'b000;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_request_conditioner.md
Name: sensor_request_conditioner

Overview:
Upstream front end of the traffic-light controller. It takes raw, asynchronous, bouncy inputs from the pedestrian button and the east-west and north-south vehicle sensors. Each channel is synchronized and debounced, and each debounced press is latched as a sticky request. The request stays on `sensors[2:0]` until the controller acknowledges service through the per-channel `clear` input.

Parameters:
- DEBOUNCE_CYCLES, default 4, number of consecutive clock cycles a synchronized level must differ from the debounced level before it is accepted. Legal range is 1 to 2^CNT_W - 1.
- CNT_W, default 20, width of each per-channel debounce counter.
- ACTIVE_LOW, default 1. When 1, the raw inputs are inverted before synchronization, because the board pushbuttons idle high.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- raw_in, input, 3: raw sensor inputs. Bit 2 = pedestrian, bit 1 = east-west, bit 0 = north-south. Asynchronous to clk.
- clear, input, 3: per-channel service acknowledge from the controller. Level-sensitive; each cycle it is high, it clears the matching request bit.
- sensors, output, 3: latched requests, same bit order as raw_in. Feeds the controller's sensors input.
- press, output, 3: one-cycle pulse per channel on each accepted debounced press.
- any_request, output, 1: OR of sensors; registered-equivalent (a direct OR of registered bits).

Behaviour:
- Reset (rst=0, asynchronous): all of the following go to 0 immediately:
  - synchronizer flops
  - debounced levels
  - debounce counters
  - sensors, press, any_request
- Reset mid-operation discards pending requests and in-progress debounce counts.
- Polarity: in = ACTIVE_LOW ? ~raw_in : raw_in. Idle logical level is 0.
- Synchronizer: two flops per channel. syncd[i] reflects in[i] after the 2nd rising edge that samples it.
- Debounce, per channel, evaluated every edge:
  - syncd == stable: cnt <= 0.
  - syncd != stable and cnt == DEBOUNCE_CYCLES-1: stable <= syncd, cnt <= 0.
  - otherwise: cnt <= cnt+1.
- Any pulse on syncd shorter than DEBOUNCE_CYCLES cycles produces no change to stable.
- Press detect: press[i] is registered high for exactly one cycle, on the edge where stable[i] goes 0→1. Release (1→0) is also debounced but produces no pulse.
- Latency: sensors[i] and press[i] rise on edge 2+DEBOUNCE_CYCLES, counting the first edge that samples the new raw level as edge 1.
- Request latch, per bit, per edge, in priority order:
  1. If a press is accepted this edge, sensors[i] <= 1. Set wins over simultaneous clear, so a new request is never lost.
  2. Else if clear[i], sensors[i] <= 0.
  3. Else hold.
- Button held: a held button produces one request only. A new request requires a debounced release followed by a debounced press.
- Held through reset: if the button is still held when reset deasserts, stable starts at 0, so one press is accepted 2+DEBOUNCE_CYCLES edges after reset release.
- Channel independence: channels are fully independent. Simultaneous presses on several channels set several bits on the same edge.
- Counter width: the counter never exceeds DEBOUNCE_CYCLES-1, so it has no wrap-around.

Test Plan:
1. Clean press (DEBOUNCE_CYCLES=4, ACTIVE_LOW=0):
   - Stimulus: raw_in=3'b100 held from edge 1.
   - Required: sensors=3'b100, press=3'b100 and any_request=1 at edge 6; press back to 0 at edge 7; sensors stays 3'b100.
2. Bounce rejection:
   - Stimulus: raw_in[1] toggles 1,0,1,0 with 3-cycle high segments, then holds high.
   - Required: no press during toggling; exactly one press[1] pulse, 6 edges after the final stable rise; sensors=3'b010.
3. Clear and collision:
   - Stimulus: with sensors=3'b001, clear=3'b001 for one cycle.
   - Required: sensors=3'b000 next edge.
   - Stimulus: repeat with a new accepted press[0] on the same edge as clear[0].
   - Required: sensors[0] stays 1.
4. Held button:
   - Stimulus: raw_in=3'b011 held 50 cycles, clear=3'b011 pulsed at cycle 20.
   - Required: one press pulse per channel only; sensors=3'b000 after the clear, with no re-assertion while held.
5. Reset mid-debounce:
   - Stimulus: assert rst=0 two cycles into a debounce count.
   - Required: sensors, press and any_request become 0 asynchronously, before the next clock edge.
   - Stimulus: release rst with raw still active.
   - Required: a press is accepted 6 edges after release.
6. ACTIVE_LOW=1:
   - Stimulus: raw_in idles 3'b111, then drops to 3'b110.
   - Required: sensors=3'b001 at edge 6; raw_in=3'b111 idle produces no request.
